// File: rtl/osc_count_capture.sv
// Counts rising edges of the selected ring oscillator inside the count window and
// captures {osc index, count, saturation} into a small result FIFO on each sample strobe.
module osc_count_capture #(
    parameter int NUM_OSC    = 10,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_OSC-1:0] osc_i,
    input  logic [4:0]         osc_sel_i,
    input  logic               count_i,
    input  logic               sample_i,
    input  logic               resetn_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [4:0]         res_osc_o,
    output logic [CNT_W-1:0]   res_count_o,
    output logic               res_sat_o,
    output logic [LVL_W-1:0]   level_o,
    output logic               overflow_o,
    input  logic               clear_ovf_i
);

    localparam int ENT_W = 5 + CNT_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [NUM_OSC-1:0] sync1_r, sync2_r;
    logic [31:0]        sync_ext_s;
    logic               sel_s, prev_r, rise_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               sat_r;

    logic [ENT_W-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_r, rd_r, rd_nx_s;
    logic [LVL_W-1:0]   level_r, level_nx_s, remain_s;
    logic [ENT_W-1:0]   head_r, head_nx_s, push_data_s;
    logic               valid_r, ovf_r;
    logic               pop_s, full_s, accept_s, drop_s;

    // Oscillator select: widening to 32 bits makes out-of-range indices read as 0.
    always_comb begin
        sync_ext_s = '0;
        for (int i = 0; i < NUM_OSC; i++) begin
            sync_ext_s[i] = sync2_r[i];
        end
        sel_s  = sync_ext_s[osc_sel_i];
        rise_s = sel_s & ~prev_r;
    end

    // Synchronisers, edge history and the saturating edge counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_r <= '0;
            sync2_r <= '0;
            prev_r  <= 1'b0;
            cnt_r   <= '0;
            sat_r   <= 1'b0;
        end else begin
            sync1_r <= osc_i;
            sync2_r <= sync1_r;
            prev_r  <= sel_s;
            if (!resetn_i) begin
                cnt_r <= '0;
                sat_r <= 1'b0;
            end else if (count_i && rise_s && (cnt_r == '1)) begin
                sat_r <= 1'b1;
            end else if (count_i && rise_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // FIFO control; a push into a full FIFO is only accepted alongside a pop.
    always_comb begin
        pop_s       = valid_r & res_ready_i;
        full_s      = (level_r == LVL_W'(FIFO_DEPTH));
        accept_s    = sample_i & (~full_s | pop_s);
        drop_s      = sample_i & full_s & ~pop_s;
        push_data_s = {osc_sel_i, cnt_r, sat_r};
        rd_nx_s     = pop_s ? rd_r + PTR_W'(1) : rd_r;
        remain_s    = level_r - LVL_W'(pop_s);
        level_nx_s  = remain_s + LVL_W'(accept_s);
        // When nothing older survives the pop, the new head is the incoming entry.
        if (remain_s == '0) begin
            head_nx_s = accept_s ? push_data_s : '0;
        end else begin
            head_nx_s = mem_r[rd_nx_s];
        end
    end

    // FIFO storage, pointers, registered head and sticky overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_r    <= '0;
            rd_r    <= '0;
            level_r <= '0;
            head_r  <= '0;
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                mem_r[wr_r] <= push_data_s;
                wr_r        <= wr_r + PTR_W'(1);
            end else begin
                wr_r <= wr_r;
            end
            rd_r    <= rd_nx_s;
            level_r <= level_nx_s;
            head_r  <= head_nx_s;
            valid_r <= (level_nx_s != '0);
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (clear_ovf_i) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign res_valid_o = valid_r;
    assign {res_osc_o, res_count_o, res_sat_o} = head_r;
    assign level_o     = level_r;
    assign overflow_o  = ovf_r;

endmodule

// File: doc/osc_count_capture.md
Name: osc_count_capture

Overview:
Downstream consumer of the sample-control sequencer in the aging readout net. Synchronises the divided ring-oscillator outputs, counts rising edges of the currently selected oscillator during the count window, and captures {osc index, count, saturation} into a small result FIFO on each sample strobe. The FIFO drains to the readout/SRAM writer through a valid/ready handshake.

Parameters:
NUM_OSC, 10, number of oscillator inputs (1..32)
CNT_W, 16, edge-counter width
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rstn  in  1  reset
osc_i  in  NUM_OSC  divided ring-oscillator outputs, asynchronous to clk
osc_sel_i  in  5  selected oscillator index from sequencer
count_i  in  1  count-window enable
sample_i  in  1  capture strobe, normally 1-cycle pulse
resetn_i  in  1  synchronous active-low counter clear from sequencer
res_valid_o  out  1  FIFO head valid
res_ready_i  in  1  consumer accepts head
res_osc_o  out  5  head: oscillator index
res_count_o  out  CNT_W  head: edge count
res_sat_o  out  1  head: counter saturated
level_o  out  clog2(FIFO_DEPTH+1)  FIFO occupancy
overflow_o  out  1  sticky: capture dropped on full FIFO
clear_ovf_i  in  1  clears overflow_o

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk. Every flop, including synchronisers, resets to 0. After reset: res_valid_o=0, level_o=0, overflow_o=0, and res_* data outputs are 0.
- Synchronisation: each osc_i bit passes through its own 2-flop synchroniser. The mux selects sync[osc_sel_i]. If osc_sel_i >= NUM_OSC, the selected value is 0.
- Edge detect: a prev register is loaded every cycle with the selected synced value. rise = sel & ~prev. An osc_i rising edge produces a rise pulse 2–3 cycles later.
- Input constraint: osc_i high and low phases are each >= 2 clk periods. Faster inputs are undefined by design; no detection is required.
- Counter, in priority order:
  - resetn_i=0: cnt=0, sat=0.
  - Else count_i & rise & cnt==2^CNT_W-1: cnt holds, sat=1.
  - Else count_i & rise: cnt+1.
  - Else: hold.
- rise outside count_i is ignored.
- osc_sel_i change: prev follows the new source. A resulting spurious rise is counted only if count_i=1. The sequencer guarantees count_i=0 and a resetn_i pulse around selection changes.
- Capture: on any cycle with sample_i=1, push {osc_sel_i, cnt, sat} using the registered values before any same-cycle increment or clear.
  - Pulses on consecutive cycles are each a separate push.
  - Capture does not clear the counter; only resetn_i clears it.
- FIFO:
  - res_valid_o = (level != 0).
  - The head is stable while res_valid_o=1 and res_ready_i=0.
  - Pop happens when res_valid_o & res_ready_i.
  - Push to an empty FIFO gives res_valid_o=1 on the next cycle (1-cycle latency).
- Full (level=FIFO_DEPTH):
  - Push without pop: data dropped, overflow_o=1 on the next cycle, level unchanged.
  - Push with pop in the same cycle: push accepted, level unchanged, no overflow.
- Empty with push and no pop: level=1. Pop is impossible when empty.
- Pointers wrap modulo FIFO_DEPTH.
- overflow_o is sticky. It is cleared by clear_ovf_i. If clear and a drop occur in the same cycle, the set wins.
- Asserting rstn mid-operation flushes the FIFO and counter immediately. Synchronisers restart, so an osc_i already high at release causes no rise.

Test Plan:
- Count window: osc_i[3] toggles with period 8 clk, osc_sel_i=3, resetn_i pulse, then count_i=1 for 400 cycles, then sample_i pulse -> one entry {osc=3, count=50±1, sat=0}; res_valid_o rises 1 cycle after sample_i.
- Gating: edges on osc_i[2] with count_i=0, then count_i=1 for exactly 5 edges, then sample_i -> count=5; unselected oscillators toggling do not contribute.
- Saturation: CNT_W=4, 20 edges in window -> count=15, sat=1; resetn_i then sample_i -> count=0, sat=0.
- Overflow: res_ready_i=0, 5 sample_i pulses with FIFO_DEPTH=4 -> level_o=4, overflow_o=1, and the first four entries are drained in order. Then with a full FIFO, sample_i and res_ready_i in the same cycle -> level_o stays 4, no new overflow. Then clear_ovf_i -> overflow_o=0.
- Out-of-range select: osc_sel_i=12 with NUM_OSC=10, all osc_i toggling -> captured count=0, res_osc_o=12.
- Reset mid-run: rstn low while level_o=3 and count=20 -> next cycle res_valid_o=0, level_o=0, counter=0.
